// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch stage and Ctrl_Unit: instruction layout,
// opcode values and fetch FSM state encodings.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int IMM_W   = 16;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPC_W-1:0] OP_ALU  = 6'd1;
    localparam logic [OPC_W-1:0] OP_LW   = 6'd2;
    localparam logic [OPC_W-1:0] OP_SW   = 6'd3;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'd4;
    localparam logic [OPC_W-1:0] OP_JUMP = 6'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port plus the issue port to decode.
//
// Handshakes:
//   imem:  imem_req is held with a stable imem_addr until imem_ack; the
//          cycle with imem_req & imem_ack transfers imem_rdata. imem_ack
//          while imem_req is low carries no meaning.
//   issue: instr_valid is held with instr/i_code/pc stable until
//          instr_ready; the cycle with instr_valid & instr_ready transfers
//          the instruction and samples pc_sel. instr_ready while
//          instr_valid is low carries no meaning.
interface instr_fetch_unit_if #(parameter int ADDR_W = 8);
    import instr_fetch_unit_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [OPC_W-1:0]    i_code;
    logic [ADDR_W-1:0]   pc;
    logic                pc_sel;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, i_code, pc,
        input  imem_ack, imem_rdata, instr_ready, pc_sel
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, i_code, pc,
        output imem_ack, imem_rdata, instr_ready, pc_sel
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: JUMP target, taken-BEQ relative target, or pc+1.
// All arithmetic is ADDR_W wide so it wraps modulo 2^ADDR_W.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               pc_sel,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] imm_adj;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_instr;

    assign opcode       = get_opcode(instr);
    // Sign-extend (or truncate) the 16-bit immediate to PC width.
    assign imm_adj      = ADDR_W'(signed'(instr[IMM_W-1:0]));
    assign pc_inc       = pc + ADDR_W'(1);
    assign unused_instr = ^instr;

    // pc_sel only matters for BEQ; JUMP always wins.
    always_comb begin
        next_pc = pc_inc;
        if (opcode == OP_JUMP) begin
            next_pc = instr[ADDR_W-1:0];
        end else if (opcode == OP_BEQ && pc_sel) begin
            next_pc = pc_inc + imm_adj;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads one instruction at a time from
// instruction memory and issues it to decode. One instruction in flight.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    instr_fetch_unit_if.master  bus,
    output logic [1:0]          state_dbg
);

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  next_pc;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
        .pc      (pc_q),
        .instr   (instr_q),
        .pc_sel  (bus.pc_sel),
        .next_pc (next_pc)
    );

    // Outputs are pure decodes of state and registers.
    assign bus.imem_req    = (state == ST_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state == ST_ISSUE);
    assign bus.instr       = instr_q;
    assign bus.i_code      = get_opcode(instr_q);
    assign bus.pc          = pc_q;
    assign state_dbg       = state;

    // FSM, PC and instruction register; run is looked at only in IDLE and at the issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.instr_ready) begin
                        pc_q  <= next_pc;
                        state <= run ? ST_REQ : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, issue-side driver, and a
// scoreboard of {pc, instr} pairs compared at each issue handshake.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int AW = 8;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [1:0] state_dbg;

    instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

    instr_fetch_unit #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW-1:0]  model_pc;

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] low);
        return {op, 10'h0, low};
    endfunction

    // Reference next-PC, using integer arithmetic then wrapping to 8 bits.
    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] p, input logic [31:0] w,
                                                 input logic sel);
        int t;
        if (w[31:26] == 6'd5) return w[AW-1:0];
        t = int'(p) + 1;
        if (w[31:26] == 6'd4 && sel) t = t + int'($signed(w[15:0]));
        return t[AW-1:0];
    endfunction

    // Bounded wait for imem_req at a negedge.
    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One fetch + issue: respond to the request after wait_c cycles, stall
    // the issue for stall_c cycles (with a stray imem_ack), then handshake.
    task automatic fetch_issue(input logic [31:0] word, input int wait_c, input int stall_c,
                               input logic sel, input logic run_after);
        logic [AW+31:0] e;
        wait_req();
        check("req_seen", {63'h0, bus.imem_req}, 64'h1);
        check("imem_addr", {56'h0, bus.imem_addr}, {56'h0, model_pc});
        repeat (wait_c) begin
            @(negedge clk);
            check("req_hold", {63'h0, bus.imem_req}, 64'h1);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        exp_q.push_back({model_pc, word});
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom();
        e = exp_q[0];
        for (int i = 0; i < stall_c; i++) begin
            check("stall_valid", {63'h0, bus.instr_valid}, 64'h1);
            check("stall_no_req", {63'h0, bus.imem_req}, 64'h0);
            check("stall_instr", {32'h0, bus.instr}, {32'h0, e[31:0]});
            check("stall_pc", {56'h0, bus.pc}, {56'h0, e[AW+31:32]});
            check("stall_icode", {58'h0, bus.i_code}, {58'h0, e[31:26]});
            bus.imem_ack = 1'b1;
            @(negedge clk);
        end
        bus.imem_ack    = 1'b0;
        run             = run_after;
        bus.instr_ready = 1'b1;
        bus.pc_sel      = sel;
        e = exp_q.pop_front();
        check("issue_valid", {63'h0, bus.instr_valid}, 64'h1);
        check("issue_pc", {56'h0, bus.pc}, {56'h0, e[AW+31:32]});
        check("issue_instr", {32'h0, bus.instr}, {32'h0, e[31:0]});
        check("issue_icode", {58'h0, bus.i_code}, {58'h0, e[31:26]});
        model_pc = model_next(e[AW+31:32], e[31:0], sel);
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
    endtask

    // Checks the address of the next request against a fixed value.
    task automatic expect_addr(input string tag, input logic [AW-1:0] a);
        wait_req();
        check(tag, {56'h0, bus.imem_addr}, {56'h0, a});
    endtask

    initial begin
        rst_n           = 1'b0;
        run             = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
        model_pc        = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pc", {56'h0, bus.pc}, 64'h0);
        check("rst_req", {63'h0, bus.imem_req}, 64'h0);
        check("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
        check("rst_icode", {58'h0, bus.i_code}, 64'h0);
        check("rst_state", {62'h0, state_dbg}, {62'h0, ST_IDLE});
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        check("first_req", {63'h0, bus.imem_req}, 64'h1);
        check("first_addr", {56'h0, bus.imem_addr}, 64'h0);

        // Sequential ALU words at 0..3, two wait cycles each.
        for (int i = 0; i < 4; i++) fetch_issue(mk(OP_ALU, 16'(i)), 2, 1, 1'b0, 1'b1);

        // BEQ at 4: taken +3, not taken, taken -2.
        fetch_issue(mk(OP_BEQ, 16'h0003), 0, 0, 1'b1, 1'b1);
        expect_addr("beq_taken", 8'h08);
        fetch_issue(mk(OP_JUMP, 16'h0004), 1, 0, 1'b0, 1'b1);
        fetch_issue(mk(OP_BEQ, 16'h0003), 0, 0, 1'b0, 1'b1);
        expect_addr("beq_not_taken", 8'h05);
        fetch_issue(mk(OP_JUMP, 16'h0004), 0, 0, 1'b0, 1'b1);
        fetch_issue(mk(OP_BEQ, 16'hFFFE), 0, 0, 1'b1, 1'b1);
        expect_addr("beq_back", 8'h03);

        // JUMP with pc_sel=1, opcode 6 with pc_sel=1, wrap at 0xFF.
        fetch_issue(mk(OP_JUMP, 16'h000A), 0, 0, 1'b0, 1'b1);
        fetch_issue(mk(OP_JUMP, 16'h0020), 0, 0, 1'b1, 1'b1);
        expect_addr("jump_tgt", 8'h20);
        fetch_issue(mk(6'd6, 16'h1234), 0, 0, 1'b1, 1'b1);
        expect_addr("op6_seq", 8'h21);
        fetch_issue(mk(OP_JUMP, 16'h00FF), 0, 0, 1'b0, 1'b1);
        fetch_issue(mk(OP_NOP, 16'h0000), 0, 0, 1'b0, 1'b1);
        expect_addr("wrap", 8'h00);

        // Long stall with stray acks.
        fetch_issue(mk(OP_LW, 16'hBEEF), 1, 5, 1'b0, 1'b1);

        // Random opcodes, waits, stalls and pc_sel.
        for (int i = 0; i < 12; i++) begin
            fetch_issue({6'($urandom_range(0, 63)), 26'($urandom())},
                        $urandom_range(0, 3), $urandom_range(0, 2),
                        1'($urandom_range(0, 1)), 1'b1);
        end

        // run dropped during ISSUE: handshake completes, then IDLE.
        fetch_issue(mk(OP_SW, 16'h0001), 1, 2, 1'b0, 1'b0);
        repeat (3) begin
            check("idle_state", {62'h0, state_dbg}, {62'h0, ST_IDLE});
            check("idle_no_req", {63'h0, bus.imem_req}, 64'h0);
            @(negedge clk);
        end
        run = 1'b1;
        fetch_issue(mk(OP_ALU, 16'h0002), 0, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of REQ.
        wait_req();
        check("pre_rst_req", {63'h0, bus.imem_req}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {63'h0, bus.imem_req}, 64'h0);
        check("async_pc", {56'h0, bus.pc}, 64'h0);
        check("async_state", {62'h0, state_dbg}, {62'h0, ST_IDLE});
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = '0;
        fetch_issue(mk(OP_ALU, 16'h0055), 0, 0, 1'b0, 1'b1);

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
